regfile_port_sequencer: RTL

- Initiator that drives the single-port register file: one shared index bus for both reads and writes, combinational read, write on clock edge.
- Takes one decoded instruction's source and destination indices from decode.
- Serialises the rs1 read, the rs2 read, operand issue to the ALU, result capture and rd writeback over that one port.
- Sits between decode, the ALU and the register file, and owns all register-file traffic.

---
 rtl/rf_seq_pkg.sv | 19 +
 rtl/regfile_port_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rf_seq_pkg.sv
// Shared widths, the x0 index and the state encoding for the register-file port sequencer.
package rf_seq_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int IDX_W_DEF     = 5;
    localparam int RF_ADDR_W_DEF = 32;

    localparam int unsigned REG_X0 = 32'd0;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD1      = 3'd1,
        RD2      = 3'd2,
        ISSUE    = 3'd3,
        WAIT_RES = 3'd4,
        WB       = 3'd5
    } state_e;

endpackage

// File: rtl/regfile_port_sequencer.sv
// Serialises rs1 read, rs2 read, ALU issue, result capture and rd writeback over one RF port.
// Optional build macro RF_READ_SKIP_EN skips reads of x0 and a repeated rs2==rs1 read.
module regfile_port_sequencer
    import rf_seq_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int IDX_W     = IDX_W_DEF,
    parameter int RF_ADDR_W = RF_ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [IDX_W-1:0]     req_rs1,
    input  logic [IDX_W-1:0]     req_rs2,
    input  logic                 req_use_rs2,
    input  logic [IDX_W-1:0]     req_rd,
    input  logic                 req_wb,
    output logic                 op_valid,
    input  logic                 op_ready,
    output logic [XLEN-1:0]      op_a,
    output logic [XLEN-1:0]      op_b,
    input  logic                 res_valid,
    output logic                 res_ready,
    input  logic [XLEN-1:0]      res_data,
    output logic [RF_ADDR_W-1:0] rf_register,
    output logic                 rf_write_enable,
    output logic [XLEN-1:0]      rf_write_data,
    input  logic [XLEN-1:0]      rf_read_data,
    output logic                 busy
);

    localparam logic [IDX_W-1:0] X0_IDX = IDX_W'(REG_X0);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic              use_rs2_q, use_rs2_d, wb_q, wb_d;
    logic [XLEN-1:0]   op_a_q, op_a_d, op_b_q, op_b_d, wb_data_q, wb_data_d;

    // Next-state and latch update logic
    always_comb begin
        state_d   = state_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        use_rs2_d = use_rs2_q;
        wb_d      = wb_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        wb_data_d = wb_data_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rs1_d     = req_rs1;
                    rs2_d     = req_rs2;
                    rd_d      = req_rd;
                    use_rs2_d = req_use_rs2;
                    wb_d      = req_wb;
`ifdef RF_READ_SKIP_EN
                    if (req_rs1 == X0_IDX) begin
                        op_a_d = '0;
                        if (!req_use_rs2 || (req_rs2 == X0_IDX)) begin
                            op_b_d  = '0;
                            state_d = ISSUE;
                        end else begin
                            state_d = RD2;
                        end
                    end else begin
                        state_d = RD1;
                    end
`else
                    state_d = RD1;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RD1: begin
                op_a_d = (rs1_q == X0_IDX) ? '0 : rf_read_data;
                if (!use_rs2_q) begin
                    op_b_d  = '0;
                    state_d = ISSUE;
                end else begin
`ifdef RF_READ_SKIP_EN
                    // rs1 is non-zero here, so a matching rs2 reuses this cycle's read
                    if (rs2_q == X0_IDX) begin
                        op_b_d  = '0;
                        state_d = ISSUE;
                    end else if (rs2_q == rs1_q) begin
                        op_b_d  = rf_read_data;
                        state_d = ISSUE;
                    end else begin
                        state_d = RD2;
                    end
`else
                    state_d = RD2;
`endif
                end
            end
            RD2: begin
                op_b_d  = (rs2_q == X0_IDX) ? '0 : rf_read_data;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (op_ready) begin
                    state_d = wb_q ? WAIT_RES : IDLE;
                end else begin
                    state_d = ISSUE;
                end
            end
            WAIT_RES: begin
                if (res_valid) begin
                    wb_data_d = res_data;
                    state_d   = WB;
                end else begin
                    state_d = WAIT_RES;
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latch registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            use_rs2_q <= 1'b0;
            wb_q      <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            use_rs2_q <= use_rs2_d;
            wb_q      <= wb_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            wb_data_q <= wb_data_d;
        end
    end

    // Port decode from state; reset forces every handshake and the RF port quiet
    always_comb begin
        req_ready       = 1'b0;
        op_valid        = 1'b0;
        res_ready       = 1'b0;
        rf_register     = '0;
        rf_write_enable = 1'b0;
        rf_write_data   = '0;
        busy            = 1'b0;
        if (rst) begin
            busy = (state_q != IDLE);
            case (state_q)
                IDLE:     req_ready = 1'b1;
                RD1:      rf_register = RF_ADDR_W'(rs1_q);
                RD2:      rf_register = RF_ADDR_W'(rs2_q);
                ISSUE:    op_valid = 1'b1;
                WAIT_RES: res_ready = 1'b1;
                WB: begin
                    rf_register     = RF_ADDR_W'(rd_q);
                    rf_write_data   = wb_data_q;
                    rf_write_enable = (rd_q != X0_IDX);
                end
                default: begin
                    busy = 1'b0;
                end
            endcase
        end else begin
            busy = 1'b0;
        end
    end

    assign op_a = op_a_q;
    assign op_b = op_b_q;

endmodule
